// File: rtl/renode_axi_manager_engine.sv
// AXI4 manager: turns a command/data stream pair into single-outstanding INCR bursts,
// with byte-lane steering, legality checks in a dedicated cycle, and response aggregation.
module renode_axi_manager_engine #(
   parameter int AddressWidth       = 32,
   parameter int DataWidth          = 32,
   parameter int TransactionIdWidth = 8,
   localparam int StrobeWidth       = DataWidth / 8
) (
   input  logic                          aclk,
   input  logic                          areset,
   // command
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [AddressWidth-1:0]       cmd_addr,
   input  logic [2:0]                    cmd_size,
   input  logic [7:0]                    cmd_len,
   input  logic [TransactionIdWidth-1:0] cmd_id,
   // write data stream
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [DataWidth-1:0]          wr_data,
   // read data stream
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [DataWidth-1:0]          rd_data,
   output logic                          rd_last,
   // completion
   output logic                          done_valid,
   output logic [1:0]                    done_resp,
   // AW
   output logic                          awvalid,
   input  logic                          awready,
   output logic [TransactionIdWidth-1:0] awid,
   output logic [AddressWidth-1:0]       awaddr,
   output logic [7:0]                    awlen,
   output logic [2:0]                    awsize,
   output logic [1:0]                    awburst,
   // W
   output logic                          wvalid,
   input  logic                          wready,
   output logic [DataWidth-1:0]          wdata,
   output logic [StrobeWidth-1:0]        wstrb,
   output logic                          wlast,
   // B
   input  logic                          bvalid,
   output logic                          bready,
   input  logic [TransactionIdWidth-1:0] bid,
   input  logic [1:0]                    bresp,
   // AR
   output logic                          arvalid,
   input  logic                          arready,
   output logic [TransactionIdWidth-1:0] arid,
   output logic [AddressWidth-1:0]       araddr,
   output logic [7:0]                    arlen,
   output logic [2:0]                    arsize,
   output logic [1:0]                    arburst,
   // R
   input  logic                          rvalid,
   output logic                          rready,
   input  logic [TransactionIdWidth-1:0] rid,
   input  logic [DataWidth-1:0]          rdata,
   input  logic [1:0]                    rresp,
   input  logic                          rlast
);

   localparam int LaneWidth = (StrobeWidth > 1) ? $clog2(StrobeWidth) : 1;
   localparam int MaxSize   = $clog2(StrobeWidth);
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_AW, S_W, S_B, S_AR, S_R, S_DONE
   } state_t;

   state_t state, state_nx;

   logic                          write_q;
   logic [AddressWidth-1:0]       addr_q;
   logic [AddressWidth-1:0]       beat_addr_q;
   logic [2:0]                    size_q;
   logic [7:0]                    len_q;
   logic [7:0]                    beat_q;
   logic [TransactionIdWidth-1:0] id_q;
   logic [1:0]                    resp_q;

   logic [7:0]             size_bytes;
   logic [LaneWidth-1:0]   lane;
   logic [19:0]            burst_end;
   logic                   illegal;
   logic                   last_beat;
   logic [StrobeWidth-1:0] strb_base;
   logic [DataWidth-1:0]   data_mask;
   logic                   r_bad;
   logic [1:0]             r_beat_resp;
   logic                   w_hs, r_hs;

   assign size_bytes = 8'd1 << size_q;
   assign lane       = LaneWidth'(beat_addr_q) & LaneWidth'(StrobeWidth - 1);
   assign last_beat  = (beat_q == len_q);

   // 20 bits hold the worst case 0xFFF + 256*128 without overflow
   assign burst_end = 20'(addr_q[11:0]) + ((20'(len_q) + 20'd1) << size_q);
   assign illegal   = (size_q > 3'(MaxSize))
                   || ((addr_q[7:0] & (size_bytes - 8'd1)) != 8'd0)
                   || (burst_end > 20'd4096);

   always_comb begin
      strb_base = '0;
      data_mask = '0;
      for (int i = 0; i < StrobeWidth; i++) begin
         strb_base[i]       = (i < int'(size_bytes));
         data_mask[8*i +: 8] = {8{strb_base[i]}};
      end
   end

   assign awid    = id_q;
   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awsize  = size_q;
   assign awburst = 2'b01;
   assign arid    = id_q;
   assign araddr  = addr_q;
   assign arlen   = len_q;
   assign arsize  = size_q;
   assign arburst = 2'b01;

   assign wdata   = wr_data << {lane, 3'b000};
   assign wstrb   = strb_base << lane;
   assign wlast   = (state == S_W) && last_beat;
   assign rd_data = (rdata >> {lane, 3'b000}) & data_mask;
   assign rd_last = (state == S_R) && last_beat;

   assign done_resp = resp_q;

   assign w_hs = (state == S_W) && wr_valid && wready;
   assign r_hs = (state == S_R) && rvalid && rd_ready;

   // A protocol violation on R counts as at least SLVERR but never hides a DECERR
   assign r_bad       = (rid != id_q) || (rlast != last_beat);
   assign r_beat_resp = (r_bad && (rresp < RespSlverr)) ? RespSlverr : rresp;

   always_ff @(posedge aclk) begin
      if (areset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      cmd_ready  = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      wr_ready   = 1'b0;
      bready     = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      rd_valid   = 1'b0;
      done_valid = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nx = S_CHECK;
         end
         S_CHECK: begin
            if (illegal)      state_nx = S_DONE;
            else if (write_q) state_nx = S_AW;
            else              state_nx = S_AR;
         end
         S_AW: begin
            awvalid = 1'b1;
            if (awready) state_nx = S_W;
         end
         S_W: begin
            wvalid   = wr_valid;
            wr_ready = wready;
            if (wr_valid && wready && last_beat) state_nx = S_B;
         end
         S_B: begin
            bready = 1'b1;
            if (bvalid) state_nx = S_DONE;
         end
         S_AR: begin
            arvalid = 1'b1;
            if (arready) state_nx = S_R;
         end
         S_R: begin
            rready   = rd_ready;
            rd_valid = rvalid;
            if (rvalid && rd_ready && last_beat) state_nx = S_DONE;
         end
         S_DONE: begin
            done_valid = 1'b1;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      // reset masks every handshake immediately so a pending beat is dropped
      if (areset) begin
         state_nx   = S_IDLE;
         cmd_ready  = 1'b0;
         awvalid    = 1'b0;
         wvalid     = 1'b0;
         wr_ready   = 1'b0;
         bready     = 1'b0;
         arvalid    = 1'b0;
         rready     = 1'b0;
         rd_valid   = 1'b0;
         done_valid = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         write_q     <= 1'b0;
         addr_q      <= '0;
         beat_addr_q <= '0;
         size_q      <= '0;
         len_q       <= '0;
         beat_q      <= '0;
         id_q        <= '0;
         resp_q      <= RespOkay;
      end else begin
         case (state)
            S_IDLE: if (cmd_valid) begin
               write_q     <= cmd_write;
               addr_q      <= cmd_addr;
               beat_addr_q <= cmd_addr;
               size_q      <= cmd_size;
               len_q       <= cmd_len;
               id_q        <= cmd_id;
               beat_q      <= '0;
               resp_q      <= RespOkay;
            end
            S_CHECK: if (illegal) resp_q <= RespSlverr;
            S_W: if (w_hs) begin
               beat_q      <= beat_q + 8'd1;
               beat_addr_q <= beat_addr_q + AddressWidth'(size_bytes);
            end
            S_B: if (bvalid) resp_q <= (bid == id_q) ? bresp : RespSlverr;
            S_R: if (r_hs) begin
               beat_q      <= beat_q + 8'd1;
               beat_addr_q <= beat_addr_q + AddressWidth'(size_bytes);
               if (r_beat_resp > resp_q) resp_q <= r_beat_resp;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_renode_axi_manager_engine.sv
// Directed bench for renode_axi_manager_engine: a scripted AXI subordinate plus
// hand-computed expectations for beats, strobes, lanes and aggregated responses.
module tb_renode_axi_manager_engine;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 8;
   localparam int SW = DW / 8;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          cmd_valid = 0, cmd_ready, cmd_write = 0;
   logic [AW-1:0] cmd_addr = '0;
   logic [2:0]    cmd_size = '0;
   logic [7:0]    cmd_len = '0;
   logic [IW-1:0] cmd_id = '0;
   logic          wr_valid = 0, wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          rd_valid, rd_ready = 0, rd_last;
   logic [DW-1:0] rd_data;
   logic          done_valid;
   logic [1:0]    done_resp;
   logic          awvalid, awready = 0;
   logic [IW-1:0] awid, arid;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic [2:0]    awsize, arsize;
   logic [1:0]    awburst, arburst;
   logic          wvalid, wready = 0, wlast;
   logic [DW-1:0] wdata;
   logic [SW-1:0] wstrb;
   logic          bvalid = 0, bready;
   logic [IW-1:0] bid = '0, rid = '0;
   logic [1:0]    bresp = '0, rresp = '0;
   logic          arvalid, arready = 0;
   logic          rvalid = 0, rready, rlast = 0;
   logic [DW-1:0] rdata = '0;

   always #5 aclk = ~aclk;

   renode_axi_manager_engine #(
      .AddressWidth(AW), .DataWidth(DW), .TransactionIdWidth(IW)
   ) dut (
      .aclk(aclk), .areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len), .cmd_id(cmd_id),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .done_valid(done_valid), .done_resp(done_resp),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // subordinate script and observations
   logic [DW-1:0] wsrc [256];
   logic [DW-1:0] rsrc [256];
   logic [1:0]    rresp_src [256];
   bit            stall, bad_bid;
   logic [7:0]    len_g;
   logic [IW-1:0] id_g;
   logic [DW-1:0] wd_q [$];
   logic [SW-1:0] ws_q [$];
   bit            wl_q [$];
   logic [DW-1:0] rd_q [$];
   bit            rl_q [$];
   int            aw_cnt, ar_cnt, done_cyc, wi, ri;
   logic [1:0]    done_r;
   logic [AW-1:0] a_addr;
   logic [7:0]    a_len;
   logic [2:0]    a_size;
   logic [1:0]    a_burst;

   task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [2:0] size,
                        input logic [7:0] len, input logic [IW-1:0] id);
      @(negedge aclk);
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_len = len; cmd_id = id;
      len_g = len; id_g = id;
      #1;
      for (int i = 0; i < 50 && !cmd_ready; i++) begin
         @(negedge aclk); #1;
      end
      check("cmd_ready", cmd_ready, 1'b1);
   endtask

   // abort_at >= 0 leaves the loop once that many W beats have been accepted
   task automatic run(input int abort_at);
      bit w_done;
      wd_q.delete(); ws_q.delete(); wl_q.delete(); rd_q.delete(); rl_q.delete();
      aw_cnt = 0; ar_cnt = 0; done_cyc = -1; wi = 0; ri = 0; w_done = 0; done_r = 2'bxx;
      for (int cyc = 1; cyc <= 3000; cyc++) begin
         @(negedge aclk);
         cmd_valid = 0;
         if (abort_at >= 0 && wi == abort_at) break;
         wr_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         wr_data  = wsrc[wi & 255];
         awready = 1; arready = 1; wready = 1;
         bvalid  = w_done;
         bid     = bad_bid ? (id_g ^ 8'h01) : id_g;
         bresp   = 2'b00;
         rvalid  = (ar_cnt > 0) && (ri <= int'(len_g)) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
         rdata   = rsrc[ri & 255];
         rresp   = rresp_src[ri & 255];
         rlast   = (ri == int'(len_g));
         rid     = id_g;
         rd_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         if (awvalid) begin aw_cnt++; a_addr = awaddr; a_len = awlen; a_size = awsize; a_burst = awburst; end
         if (arvalid) begin ar_cnt++; a_addr = araddr; a_len = arlen; a_size = arsize; a_burst = arburst; end
         if (wvalid && wready) begin
            wd_q.push_back(wdata); ws_q.push_back(wstrb); wl_q.push_back(wlast);
            if (wlast) w_done = 1;
            wi++;
         end
         if (rvalid && rready) begin
            rd_q.push_back(rd_data); rl_q.push_back(rd_last); ri++;
         end
         if (done_valid) begin done_cyc = cyc; done_r = done_resp; break; end
      end
      bvalid = 0; rvalid = 0;
      if (abort_at < 0) begin
         check("done_seen", done_cyc >= 0, 1'b1);
         @(negedge aclk); #1;
         check("done_one_cycle", done_valid, 1'b0);
      end
   endtask

   initial begin
      stall = 0; bad_bid = 0;
      for (int i = 0; i < 256; i++) begin wsrc[i] = '0; rsrc[i] = '0; rresp_src[i] = '0; end

      // reset state
      repeat (2) @(negedge aclk);
      #1;
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_valids", {awvalid, arvalid, wvalid, bready, rready, rd_valid, done_valid, wr_ready}, 8'h00);
      check("rst_done_resp", done_resp, 2'b00);
      check("rst_awaddr", awaddr, 32'h0);
      check("rst_awlen_id", {awlen, awid}, 16'h0);
      @(negedge aclk); areset = 0;
      @(negedge aclk); #1;
      check("cmd_ready_after_rst", cmd_ready, 1'b1);

      // single-beat write
      wsrc[0] = 32'hDEADBEEF;
      issue(1, 32'h1000, 3'd2, 8'd0, 8'h5A);
      run(-1);
      check("t1_aw", {a_addr, a_len, 5'(a_size), 6'(a_burst)}, {32'h1000, 8'd0, 5'd2, 6'd1});
      check("t1_aw_cnt", aw_cnt, 1);
      check("t1_beats", wd_q.size(), 1);
      check("t1_wdata", wd_q[0], 32'hDEADBEEF);
      check("t1_wstrb", ws_q[0], 4'hF);
      check("t1_wlast", wl_q[0], 1'b1);
      check("t1_resp", done_r, 2'b00);

      // 4-beat read
      for (int i = 0; i < 4; i++) rsrc[i] = 32'h11 * (i + 1);
      issue(0, 32'h2000, 3'd2, 8'd3, 8'h21);
      run(-1);
      check("t2_ar", {a_addr, a_len, 5'(a_size), 6'(a_burst)}, {32'h2000, 8'd3, 5'd2, 6'd1});
      check("t2_beats", rd_q.size(), 4);
      check("t2_data", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, {32'h11, 32'h22, 32'h33, 32'h44});
      check("t2_last", {rl_q[0], rl_q[1], rl_q[2], rl_q[3]}, 4'b0001);
      check("t2_resp", done_r, 2'b00);

      // byte writes steered to lanes 1 and 2
      wsrc[0] = 32'hAB; wsrc[1] = 32'hCD;
      issue(1, 32'h3001, 3'd0, 8'd1, 8'h03);
      run(-1);
      check("t3_beats", wd_q.size(), 2);
      check("t3_b0", {wd_q[0], ws_q[0], 4'(wl_q[0])}, {32'h0000AB00, 4'h2, 4'h0});
      check("t3_b1", {wd_q[1], ws_q[1], 4'(wl_q[1])}, {32'h00CD0000, 4'h4, 4'h1});
      check("t3_resp", done_r, 2'b00);

      // byte read from lane 3
      rsrc[0] = 32'hA1B2C3D4;
      issue(0, 32'h5003, 3'd0, 8'd0, 8'h04);
      run(-1);
      check("t3r_data", rd_q[0], 32'h000000A1);
      check("t3r_last", rl_q[0], 1'b1);

      // misaligned: rejected in CHECK, done two cycles after acceptance
      issue(1, 32'h4002, 3'd2, 8'd0, 8'h05);
      run(-1);
      check("t4_no_addr", aw_cnt + ar_cnt, 0);
      check("t4_no_wbeats", wi, 0);
      check("t4_latency", done_cyc, 2);
      check("t4_resp", done_r, 2'b10);

      // 4 KiB crossing, exact-boundary burst, oversize beat
      issue(0, 32'h0FFC, 3'd2, 8'd1, 8'h06);
      run(-1);
      check("t4k_cross", {8'(aw_cnt + ar_cnt), 6'(done_r)}, {8'd0, 6'd2});
      for (int i = 0; i < 2; i++) rsrc[i] = 32'hC0DE0000 + i;
      issue(0, 32'h0FF8, 3'd2, 8'd1, 8'h07);
      run(-1);
      check("t4k_edge", {8'(ar_cnt), 8'(rd_q.size()), 6'(done_r)}, {8'd1, 8'd2, 6'd0});
      issue(1, 32'h7000, 3'd3, 8'd0, 8'h08);
      run(-1);
      check("t_oversize", {8'(aw_cnt), 8'(wi), 6'(done_r)}, {8'd0, 8'd0, 6'd2});

      // read with random stalls and SLVERR on beat 5
      stall = 1;
      for (int i = 0; i < 8; i++) begin rsrc[i] = 32'h01010101 * (i + 1); rresp_src[i] = 2'b00; end
      rresp_src[5] = 2'b10;
      issue(0, 32'h6000, 3'd2, 8'd7, 8'h09);
      run(-1);
      check("t5_beats", rd_q.size(), 8);
      for (int i = 0; i < 8 && i < rd_q.size(); i++)
         check($sformatf("t5_data%0d", i), rd_q[i], 32'h01010101 * (i + 1));
      check("t5_last", rl_q.size() == 8 ? rl_q[7] : 1'b0, 1'b1);
      check("t5_resp", done_r, 2'b10);
      stall = 0;
      for (int i = 0; i < 8; i++) rresp_src[i] = 2'b00;

      // wrong bid
      bad_bid = 1;
      wsrc[0] = 32'h12345678;
      issue(1, 32'h9000, 3'd2, 8'd0, 8'h0A);
      run(-1);
      check("t_badbid_resp", done_r, 2'b10);
      bad_bid = 0;

      // 256-beat read, counter must not wrap early
      for (int i = 0; i < 256; i++) rsrc[i] = i;
      issue(0, 32'h8000, 3'd2, 8'd255, 8'h0B);
      run(-1);
      check("t_256_beats", rd_q.size(), 256);
      check("t_256_tail", rd_q.size() == 256 ? rd_q[255] : 32'hFFFFFFFF, 32'd255);
      check("t_256_last", rl_q.size() == 256 ? {rl_q[254], rl_q[255]} : 2'b11, 2'b01);
      check("t_256_resp", done_r, 2'b00);

      // reset in the middle of a write burst
      for (int i = 0; i < 4; i++) wsrc[i] = 32'hF00D0000 + i;
      issue(1, 32'hA000, 3'd2, 8'd3, 8'h0C);
      run(2);
      areset = 1;
      #1;
      check("t6_masked", {awvalid, wvalid, wr_ready, cmd_ready}, 4'b0000);
      @(negedge aclk); #1;
      check("t6_after_edge", {awvalid, wvalid, bready, done_valid}, 4'b0000);
      areset = 0;
      @(negedge aclk); #1;
      check("t6_cmd_ready", cmd_ready, 1'b1);
      check("t6_no_done", done_valid, 1'b0);
      wsrc[0] = 32'h0BADF00D;
      issue(1, 32'hB000, 3'd2, 8'd0, 8'h0D);
      run(-1);
      check("t6_next", {wd_q.size() == 1 ? wd_q[0] : 32'h0, 30'(done_r)}, {32'h0BADF00D, 30'd0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/renode_axi_manager_engine.md
Name: renode_axi_manager_engine

Overview:
- Synthesizable AXI4 manager (initiator) that turns simple command/data streams into AXI4 INCR bursts. It is the counterpart of the Renode-side AXI subordinate.
- Lets an HDL-side agent issue reads and writes onto an AXI fabric.
- Handles one outstanding transaction at a time, with byte-lane steering, address-legality checks and response aggregation.

Parameters:
- AddressWidth, 32, width of cmd_addr/awaddr/araddr.
- DataWidth, 32, AXI data width (power of 2, 8..512); StrobeWidth = DataWidth/8.
- TransactionIdWidth, 8, width of cmd_id and the AXI id fields.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AddressWidth  start byte address.
- cmd_size  in  3  bytes per beat = 2**cmd_size.
- cmd_len  in  8  beats - 1.
- cmd_id  in  TransactionIdWidth  AXI id.
- wr_valid / wr_ready  in / out  1  write-data beat handshake.
- wr_data  in  DataWidth  beat data, right-aligned (LSB = first byte).
- rd_valid / rd_ready  out / in  1  read-data beat handshake.
- rd_data  out  DataWidth  beat data, right-aligned, unused bytes zero.
- rd_last  out  1  last read beat.
- done_valid  out  1  one-cycle completion pulse.
- done_resp  out  2  aggregated response (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR).
- AW: awvalid out 1, awready in 1, awid/awaddr/awlen(8)/awsize(3)/awburst(2) out.
- W: wvalid out 1, wready in 1, wdata out DataWidth, wstrb out StrobeWidth, wlast out 1.
- B: bvalid in 1, bready out 1, bid in TransactionIdWidth, bresp in 2.
- AR: arvalid out 1, arready in 1, arid/araddr/arlen/arsize/arburst out.
- R: rvalid in 1, rready out 1, rid in TransactionIdWidth, rdata in DataWidth, rresp in 2, rlast in 1.

Behaviour:
- Reset:
  - While areset=1, state IDLE and all valid/ready outputs 0, including cmd_ready, bready, rready, done_valid.
  - done_resp=00, address/len/id registers 0.
  - cmd_ready rises the cycle after areset falls.
  - Reset asserted mid-transaction abandons the transaction at the next edge: no done pulse, no further beats, and the subordinate's pending handshake is dropped.
- FSM states: IDLE, CHECK, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch the command and go to CHECK. Registered, so awvalid/arvalid can assert no earlier than 2 cycles after acceptance.
- CHECK (one cycle): the command is illegal if any of the following hold:
  - 2**cmd_size > StrobeWidth;
  - cmd_addr % 2**cmd_size != 0;
  - the burst crosses a 4 KiB boundary (addr[11:0] + (len+1)*2**size > 4096).
  - Illegal → DONE with done_resp=10, no AXI activity, and no wr beats consumed.
  - Legal → AW (write) or AR (read).
- Address phase:
  - awburst/arburst fixed 2'b01 (INCR); id/addr/len/size taken from the latched command.
  - Valid held stable until ready. On handshake go to W or R.
- W:
  - Beat address starts at cmd_addr and increments by 2**size each accepted beat.
  - lane = beat_addr % StrobeWidth.
  - wdata = wr_data << 8*lane.
  - wstrb = ((1<<2**size)-1) << lane.
  - wlast=1 on beat len.
  - wvalid=wr_valid and wr_ready=wready, valid only in W; data is never dropped or duplicated.
  - After the last beat handshake go to B.
- B:
  - bready=1.
  - On bvalid: done_resp = bresp if bid==cmd_id, else 10. Then go to DONE.
- R:
  - rready=rd_ready, rd_valid=rvalid (R state only).
  - rd_data = (rdata >> 8*lane) masked to 2**size bytes.
  - rd_last = beat counter == len.
  - Accumulated resp = numeric max over beats of rresp. rid≠cmd_id or rlast≠(beat==len) forces 10.
  - After the beat == len handshake go to DONE.
- DONE: done_valid=1 for exactly one cycle, then IDLE. cmd_ready is 0 during DONE.
- Beat counter is 8-bit; len=255 (256 beats) must complete without wrap.

Test Plan:
- Write, addr 0x1000, size 2, len 0, wr_data 0xDEADBEEF, awready/wready/bvalid immediate, bresp 00.
  → AW addr 0x1000 len 0 size 2 burst 01; wdata 0xDEADBEEF, wstrb 0xF, wlast 1; done_resp 00.
- Read, addr 0x2000, size 2, len 3; subordinate returns 0x11..0x44, rlast on beat 3.
  → rd_data 0x11,0x22,0x33,0x44; rd_last only on the 4th beat; done_resp 00.
- Write, addr 0x3001, size 0, len 1, wr_data 0xAB then 0xCD.
  → wdata 0x0000AB00 with wstrb 0x2, then 0x00CD0000 with wstrb 0x4; wlast on beat 2.
- Misaligned command, addr 0x4002, size 2.
  → no awvalid/arvalid ever asserted; done_valid pulse with done_resp 10, 2 cycles after acceptance.
- Read, len 7, with rvalid/rd_ready randomly deasserted and beat 5 rresp=10.
  → all 8 beats delivered in order; done_resp 10.
- Write, len 3, with areset pulsed after beat 1.
  → wvalid/awvalid 0 next cycle; no done_valid; cmd_ready 1 the cycle after reset release; a following command completes normally.
